// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the execute stage and the
// debug/loader port: grant FSM, latched request, fixed-latency access, done pulse.
module dmem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_req,
  input  logic        ex_we,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic [31:0] ex_rdata,
  output logic        ex_done,
  output logic        stall_ex,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_done,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_EX, OWN_DBG} owner_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_nxt;
  owner_t     owner;
  logic       we_q;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;

  logic starved;
  logic grant_dbg;
  logic grant_ex;

  // DBG only overtakes a pending EX request once EX has been granted
  // STARVE_MAX times in a row while DBG was waiting.
  assign starved   = (starve_cnt == STARVE_LIM);
  assign grant_dbg = dbg_req & (~ex_req | starved);
  assign grant_ex  = ex_req & ~grant_dbg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ex_done   = 1'b0;
    dbg_done  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ex || grant_dbg) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_read  = ~we_q;
        mem_write = we_q;
        if (lat_cnt == 3'd0) state_nxt = DONE;
      end
      DONE: begin
        ex_done   = (owner == OWN_EX);
        dbg_done  = (owner == OWN_DBG);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_ex = ex_req & ~ex_done;

  // Request latch, latency counter, starvation counter and read-data capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner       <= OWN_EX;
      we_q        <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      ex_rdata    <= '0;
      dbg_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dbg) begin
            owner       <= OWN_DBG;
            we_q        <= dbg_we;
            mem_address <= dbg_addr;
            mem_wdata   <= dbg_wdata;
            lat_cnt     <= LAT_INIT;
          end else if (grant_ex) begin
            owner       <= OWN_EX;
            we_q        <= ex_we;
            mem_address <= ex_addr;
            mem_wdata   <= ex_wdata;
            lat_cnt     <= LAT_INIT;
          end
          if (grant_dbg || !dbg_req) begin
            starve_cnt <= '0;
          end else if (grant_ex && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ACCESS: begin
          if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else if (!we_q) begin
            if (owner == OWN_DBG) dbg_rdata <= mem_rdata;
            else                  ex_rdata  <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances (MEM_LAT=1/STARVE_MAX=2 and
// MEM_LAT=3/STARVE_MAX=4), each with its own small memory model.
module tb_dmem_arbiter;

  typedef struct {
    int          d;
    bit          dbg;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clock;
  logic        reset_n     [2];
  logic        ex_req      [2];
  logic        ex_we       [2];
  logic [31:0] ex_addr     [2];
  logic [31:0] ex_wdata    [2];
  logic [31:0] ex_rdata    [2];
  logic        ex_done     [2];
  logic        stall_ex    [2];
  logic        dbg_req     [2];
  logic        dbg_we      [2];
  logic [31:0] dbg_addr    [2];
  logic [31:0] dbg_wdata   [2];
  logic [31:0] dbg_rdata   [2];
  logic        dbg_done    [2];
  logic [31:0] mem_address [2];
  logic [31:0] mem_wdata   [2];
  logic        mem_read    [2];
  logic        mem_write   [2];
  logic [31:0] mem_rdata   [2];

  logic [31:0] model_ex_rdata  [2];
  logic [31:0] model_dbg_rdata [2];

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) u_dut0 (
    .clock(clock), .reset_n(reset_n[0]),
    .ex_req(ex_req[0]), .ex_we(ex_we[0]), .ex_addr(ex_addr[0]), .ex_wdata(ex_wdata[0]),
    .ex_rdata(ex_rdata[0]), .ex_done(ex_done[0]), .stall_ex(stall_ex[0]),
    .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
    .dbg_rdata(dbg_rdata[0]), .dbg_done(dbg_done[0]),
    .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut1 (
    .clock(clock), .reset_n(reset_n[1]),
    .ex_req(ex_req[1]), .ex_we(ex_we[1]), .ex_addr(ex_addr[1]), .ex_wdata(ex_wdata[1]),
    .ex_rdata(ex_rdata[1]), .ex_done(ex_done[1]), .stall_ex(stall_ex[1]),
    .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
    .dbg_rdata(dbg_rdata[1]), .dbg_done(dbg_done[1]),
    .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1])
  );

  // Memory model: unwritten words read back a fixed pattern, 0x40 holds 0x1234.
  bit [31:0] mem0 [256];
  bit        wr0  [256];
  bit [31:0] mem1 [256];
  bit        wr1  [256];

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h40) ? 32'h0000_1234 : (32'hCAFE_0000 | {24'h0, a});
  endfunction

  always @(posedge clock) begin
    if (mem_write[0]) begin
      mem0[mem_address[0][7:0]] <= mem_wdata[0];
      wr0[mem_address[0][7:0]]  <= 1'b1;
    end
    if (mem_write[1]) begin
      mem1[mem_address[1][7:0]] <= mem_wdata[1];
      wr1[mem_address[1][7:0]]  <= 1'b1;
    end
  end

  always_comb begin
    mem_rdata[0] = 32'hBAD0_BAD0;
    mem_rdata[1] = 32'hBAD0_BAD0;
    if (mem_read[0])
      mem_rdata[0] = wr0[mem_address[0][7:0]] ? mem0[mem_address[0][7:0]] : init_word(mem_address[0][7:0]);
    if (mem_read[1])
      mem_rdata[1] = wr1[mem_address[1][7:0]] ? mem1[mem_address[1][7:0]] : init_word(mem_address[1][7:0]);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_rdata(input int d, input string tag);
    check({tag, "_ex_rdata"}, ex_rdata[d], model_ex_rdata[d]);
    check({tag, "_dbg_rdata"}, dbg_rdata[d], model_dbg_rdata[d]);
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_strobes"}, {30'd0, mem_read[d], mem_write[d]}, 32'd0);
    check({tag, "_dones"}, {30'd0, ex_done[d], dbg_done[d]}, 32'd0);
    check({tag, "_mem_address"}, mem_address[d], 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata[d], 32'd0);
    check({tag, "_ex_rdata"}, ex_rdata[d], 32'd0);
    check({tag, "_dbg_rdata"}, dbg_rdata[d], 32'd0);
  endtask

  // One isolated access, started at a negedge with the DUT idle.
  task automatic do_access(input vec_t v, input string tag);
    int d;
    int lat;
    d   = v.d;
    lat = (d == 0) ? 1 : 3;
    if (v.dbg) begin
      dbg_req[d] = 1'b1; dbg_we[d] = v.we; dbg_addr[d] = v.addr; dbg_wdata[d] = v.wdata;
    end else begin
      ex_req[d] = 1'b1; ex_we[d] = v.we; ex_addr[d] = v.addr; ex_wdata[d] = v.wdata;
    end
    #1;
    check({tag, "_stall_c0"}, 32'(stall_ex[d]), 32'(!v.dbg));
    for (int i = 1; i <= lat; i++) begin
      @(negedge clock);
      check($sformatf("%s_strobe_c%0d", tag, i), {30'd0, mem_read[d], mem_write[d]}, {30'd0, !v.we, v.we});
      check($sformatf("%s_nodone_c%0d", tag, i), {30'd0, ex_done[d], dbg_done[d]}, 32'd0);
      check($sformatf("%s_stall_c%0d", tag, i), 32'(stall_ex[d]), 32'(!v.dbg));
    end
    check({tag, "_mem_address"}, mem_address[d], v.addr);
    if (v.we) check({tag, "_mem_wdata"}, mem_wdata[d], v.wdata);
    @(negedge clock);
    check({tag, "_done"}, {30'd0, ex_done[d], dbg_done[d]}, {30'd0, !v.dbg, v.dbg});
    check({tag, "_strobe_done"}, {30'd0, mem_read[d], mem_write[d]}, 32'd0);
    check({tag, "_stall_done"}, 32'(stall_ex[d]), 32'd0);
    if (!v.we) begin
      if (v.dbg) model_dbg_rdata[d] = v.exp_rdata;
      else       model_ex_rdata[d]  = v.exp_rdata;
    end
    check_rdata(d, tag);
    ex_req[d]  = 1'b0;
    dbg_req[d] = 1'b0;
    @(negedge clock);
    check({tag, "_done_gone"}, {30'd0, ex_done[d], dbg_done[d]}, 32'd0);
    check({tag, "_addr_hold"}, mem_address[d], v.addr);
    check_rdata(d, {tag, "_idle"});
  endtask

  vec_t tv [8];
  vec_t post;
  logic exp_order [4];
  bit   seen;
  bit   got_dbg;

  initial begin
    tv[0] = '{d: 0, dbg: 1'b0, we: 1'b0, addr: 32'h40, wdata: 32'h0,           exp_rdata: 32'h0000_1234};
    tv[1] = '{d: 1, dbg: 1'b1, we: 1'b1, addr: 32'h08, wdata: 32'hDEAD_BEEF,   exp_rdata: 32'h0};
    tv[2] = '{d: 1, dbg: 1'b0, we: 1'b0, addr: 32'h08, wdata: 32'h0,           exp_rdata: 32'hDEAD_BEEF};
    tv[3] = '{d: 0, dbg: 1'b0, we: 1'b1, addr: 32'h10, wdata: 32'hA5A5_0001,   exp_rdata: 32'h0};
    tv[4] = '{d: 0, dbg: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0,           exp_rdata: 32'hA5A5_0001};
    tv[5] = '{d: 0, dbg: 1'b1, we: 1'b1, addr: 32'h11, wdata: 32'h0F0F_F0F0,   exp_rdata: 32'h0};
    tv[6] = '{d: 0, dbg: 1'b0, we: 1'b0, addr: 32'h11, wdata: 32'h0,           exp_rdata: 32'h0F0F_F0F0};
    tv[7] = '{d: 1, dbg: 1'b0, we: 1'b0, addr: 32'h20, wdata: 32'h0,           exp_rdata: 32'hCAFE_0020};
    exp_order = '{1'b0, 1'b0, 1'b1, 1'b0};

    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0;
      ex_req[d] = 1'b0; ex_we[d] = 1'b0; ex_addr[d] = '0; ex_wdata[d] = '0;
      dbg_req[d] = 1'b0; dbg_we[d] = 1'b0; dbg_addr[d] = '0; dbg_wdata[d] = '0;
      model_ex_rdata[d] = '0; model_dbg_rdata[d] = '0;
    end
    repeat (2) @(negedge clock);
    check_reset_outputs(0, "rst0");
    check_reset_outputs(1, "rst1");
    check("rst0_starve", 32'(u_dut0.starve_cnt), 32'd0);
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 8; i++) do_access(tv[i], $sformatf("v%0d", i));

    // Tie on the MEM_LAT=1 instance: EX first, DBG in the following access slot.
    ex_req[0] = 1'b1; ex_we[0] = 1'b0; ex_addr[0] = 32'h40;
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b0; dbg_addr[0] = 32'h10;
    #1 check("tie_stall_c0", 32'(stall_ex[0]), 32'd1);
    @(negedge clock);
    check("tie_c1_read", 32'(mem_read[0]), 32'd1);
    check("tie_c1_addr", mem_address[0], 32'h40);
    @(negedge clock);
    check("tie_c2_dones", {30'd0, ex_done[0], dbg_done[0]}, 32'd2);
    model_ex_rdata[0] = 32'h0000_1234;
    check_rdata(0, "tie_c2");
    ex_req[0] = 1'b0;
    @(negedge clock);
    check("tie_c3_idle", {30'd0, mem_read[0], dbg_done[0]}, 32'd0);
    @(negedge clock);
    check("tie_c4_addr", mem_address[0], 32'h10);
    check("tie_c4_read", 32'(mem_read[0]), 32'd1);
    @(negedge clock);
    check("tie_c5_dones", {30'd0, ex_done[0], dbg_done[0]}, 32'd1);
    model_dbg_rdata[0] = 32'hA5A5_0001;
    check_rdata(0, "tie_c5");
    dbg_req[0] = 1'b0;
    @(negedge clock);

    // Starvation with STARVE_MAX=2: DBG held, EX kept requesting.
    ex_req[0] = 1'b1; ex_we[0] = 1'b0; ex_addr[0] = 32'h40;
    dbg_req[0] = 1'b1; dbg_we[0] = 1'b0; dbg_addr[0] = 32'h11;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      got_dbg = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge clock);
        if (ex_done[0] || dbg_done[0]) begin
          seen = 1'b1;
          got_dbg = dbg_done[0];
        end
      end
      check($sformatf("starve_seen_%0d", k), 32'(seen), 32'd1);
      check($sformatf("starve_order_%0d", k), 32'(got_dbg), 32'(exp_order[k]));
      if (k == 1) check("starve_cnt_sat", 32'(u_dut0.starve_cnt), 32'd2);
      if (k == 2) begin
        check("starve_cnt_clear", 32'(u_dut0.starve_cnt), 32'd0);
        check("starve_dbg_rdata", dbg_rdata[0], 32'h0F0F_F0F0);
        dbg_req[0] = 1'b0;
      end
      if (k == 3) begin
        check("starve_ex_rdata", ex_rdata[0], 32'h0000_1234);
        ex_req[0] = 1'b0;
      end
    end
    @(negedge clock);
    check("starve_end_cnt", 32'(u_dut0.starve_cnt), 32'd0);

    // Reset during the second ACCESS cycle of a MEM_LAT=3 write.
    ex_req[1] = 1'b1; ex_we[1] = 1'b1; ex_addr[1] = 32'h30; ex_wdata[1] = 32'h1111_2222;
    @(negedge clock);
    check("rma_c1_write", 32'(mem_write[1]), 32'd1);
    @(negedge clock);
    check("rma_c2_write", 32'(mem_write[1]), 32'd1);
    reset_n[1] = 1'b0;
    #1;
    check_reset_outputs(1, "rma");
    ex_req[1] = 1'b0;
    model_ex_rdata[1]  = '0;
    model_dbg_rdata[1] = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("rma_nodone_%0d", c), {30'd0, ex_done[1], mem_write[1]}, 32'd0);
    end
    reset_n[1] = 1'b1;
    @(negedge clock);
    post = '{d: 1, dbg: 1'b0, we: 1'b1, addr: 32'h30, wdata: 32'h1111_2222, exp_rdata: 32'h0};
    do_access(post, "rma_reissue");
    post = '{d: 1, dbg: 1'b1, we: 1'b0, addr: 32'h30, wdata: 32'h0, exp_rdata: 32'h1111_2222};
    do_access(post, "rma_readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
